// File: rtl/spi_slave_nbit.sv
// SPI slave, DATA_W-bit words, all SPI pins oversampled in sys_clk (CPOL/CPHA/bit order by parameter).
// Latency: rx_valid one sys_clk after the detected sample edge of the last bit; MISO follows the shifter by one cycle.
// Backpressure: none; a word completing while rx_valid is high overwrites rx_data and sets sticky rx_overrun.
module spi_slave_nbit #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              CS_N,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    input  logic              ovr_clr,
    output logic              busy
);

    localparam int   CNT_W    = $clog2(DATA_W + 1);
    localparam logic SCK_IDLE = (CPOL != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic                   cs_d, sck_d;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_sh, tx_sh;
    logic                   reload_pend, skip_shift;

    logic cs_s, sck_s, mosi_s, cs_fall, cs_rise, lead_edge, trail_edge;
    logic sample_edge, shift_edge, word_end, tx_first;
    logic [DATA_W-1:0] rx_next, tx_shifted;

    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign cs_fall    = cs_d & ~cs_s;
    assign cs_rise    = ~cs_d & cs_s;
    assign lead_edge  = (sck_d == SCK_IDLE) && (sck_s != SCK_IDLE);
    assign trail_edge = (sck_d != SCK_IDLE) && (sck_s == SCK_IDLE);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign word_end    = sample_edge && (bit_cnt == CNT_W'(DATA_W - 1));
    assign rx_next     = (MSB_FIRST != 0) ? {rx_sh[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh[DATA_W-1:1]};
    assign tx_shifted  = (MSB_FIRST != 0) ? {tx_sh[DATA_W-2:0], 1'b0} : {1'b0, tx_sh[DATA_W-1:1]};
    assign tx_first    = (MSB_FIRST != 0) ? tx_sh[DATA_W-1] : tx_sh[0];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sck_d     <= SCK_IDLE;
            fill      <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            cs_d      <= cs_s;
            sck_d     <= sck_s;
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            armed       <= 1'b0;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            reload_pend <= 1'b0;
            skip_shift  <= 1'b0;
            tx_load     <= 1'b0;
            MISO        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            // Only a CS_N fall seen after a genuine high level starts a transfer,
            // so a reset released mid-transfer waits for the next frame.
            armed   <= armed | (fill[SYNC_STAGES] & cs_s & cs_d);
            if (rx_ack)  rx_valid   <= 1'b0;
            if (ovr_clr) rx_overrun <= 1'b0;

            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    busy <= 1'b0;
                    if (cs_fall && armed) begin
                        state       <= ACTIVE;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        rx_sh       <= '0;
                        tx_sh       <= tx_data;
                        tx_load     <= 1'b1;
                        reload_pend <= 1'b0;
                        skip_shift  <= (CPHA != 0);
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        MISO        <= 1'b0;
                        bit_cnt     <= '0;
                        rx_sh       <= '0;
                        reload_pend <= 1'b0;
                    end else begin
                        MISO <= tx_first;
                        if (sample_edge) begin
                            rx_sh <= rx_next;
                            if (word_end) begin
                                bit_cnt     <= '0;
                                rx_data     <= rx_next;
                                rx_valid    <= 1'b1;
                                reload_pend <= 1'b1;
                                if (rx_valid) rx_overrun <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        // With CPHA=1 the first shift edge of a frame only confirms the preloaded bit.
                        if (shift_edge) begin
                            if (reload_pend) begin
                                tx_sh       <= tx_data;
                                tx_load     <= 1'b1;
                                reload_pend <= 1'b0;
                            end else if (skip_shift) begin
                                skip_shift <= 1'b0;
                            end else begin
                                tx_sh <= tx_shifted;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_nbit.sv
// Directed bench: mode 0 / mode 3 / 16-bit LSB-first instances of spi_slave_nbit driven by a bit-banged master.
module tb_spi_slave_nbit;

    localparam int HALF = 8;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [2:0] cs_n    = 3'b111;
    logic [2:0] sck     = 3'b010;
    logic [2:0] mosi    = 3'b000;
    logic [2:0] rx_ack  = 3'b000;
    logic [2:0] ovr_clr = 3'b000;
    logic [2:0] miso, tx_load, rx_valid, rx_overrun, busy;
    logic [7:0]  txd0 = 8'h00, txd1 = 8'h00, rxd0, rxd1;
    logic [15:0] txd2 = 16'h0000, rxd2;

    int checks = 0;
    int fails  = 0;
    int ld_cnt [3] = '{0, 0, 0};

    spi_slave_nbit #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .CS_N(cs_n[0]), .SCK(sck[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .tx_data(txd0), .tx_load(tx_load[0]), .rx_data(rxd0),
        .rx_valid(rx_valid[0]), .rx_ack(rx_ack[0]), .rx_overrun(rx_overrun[0]),
        .ovr_clr(ovr_clr[0]), .busy(busy[0]));

    spi_slave_nbit #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .CS_N(cs_n[1]), .SCK(sck[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .tx_data(txd1), .tx_load(tx_load[1]), .rx_data(rxd1),
        .rx_valid(rx_valid[1]), .rx_ack(rx_ack[1]), .rx_overrun(rx_overrun[1]),
        .ovr_clr(ovr_clr[1]), .busy(busy[1]));

    spi_slave_nbit #(.DATA_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .CS_N(cs_n[2]), .SCK(sck[2]), .MOSI(mosi[2]),
        .MISO(miso[2]), .tx_data(txd2), .tx_load(tx_load[2]), .rx_data(rxd2),
        .rx_valid(rx_valid[2]), .rx_ack(rx_ack[2]), .rx_overrun(rx_overrun[2]),
        .ovr_clr(ovr_clr[2]), .busy(busy[2]));

    always @(posedge sys_clk) begin
        for (int i = 0; i < 3; i++)
            if (tx_load[i] === 1'b1) ld_cnt[i] <= ld_cnt[i] + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic cs_begin(input int d);
        cs_n[d] = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_end(input int d);
        cs_n[d] = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic ack(input int d);
        rx_ack[d] = 1'b1;
        wait_cyc(1);
        rx_ack[d] = 1'b0;
        wait_cyc(1);
    endtask

    // Bit-banged master; miso_seen holds MISO at each sample edge in word bit positions,
    // v2/v3 are rx_valid two and three cycles after the final sample edge.
    task automatic xfer_word(input int d, input logic cpol, input logic cpha, input int nbits,
                             input logic lsb, input logic [31:0] data,
                             output logic [31:0] miso_seen, output logic v2, output logic v3);
        int idx;
        miso_seen = '0;
        v2 = 1'b0;
        v3 = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : nbits - 1 - i;
            if (!cpha) begin
                mosi[d] = data[idx];
                wait_cyc(HALF);
                miso_seen[idx] = miso[d];
                sck[d] = ~cpol;
            end else begin
                sck[d] = ~cpol;
                wait_cyc(HALF / 2);
                mosi[d] = data[idx];
                wait_cyc(HALF / 2);
                miso_seen[idx] = miso[d];
                sck[d] = cpol;
            end
            if (i == nbits - 1) begin
                wait_cyc(2);
                v2 = rx_valid[d];
                wait_cyc(1);
                v3 = rx_valid[d];
                wait_cyc(HALF - 3);
            end else begin
                wait_cyc(HALF);
            end
            if (!cpha) sck[d] = cpol;
        end
        wait_cyc(HALF);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_cyc(3);
        checks++; if (miso !== 3'b000) begin fails++; $display("FAIL rst_miso got=%b exp=000", miso); end
        checks++; if (tx_load !== 3'b000) begin fails++; $display("FAIL rst_tx_load got=%b exp=000", tx_load); end
        checks++; if (rx_valid !== 3'b000) begin fails++; $display("FAIL rst_rx_valid got=%b exp=000", rx_valid); end
        checks++; if (rx_overrun !== 3'b000) begin fails++; $display("FAIL rst_overrun got=%b exp=000", rx_overrun); end
        checks++; if (busy !== 3'b000) begin fails++; $display("FAIL rst_busy got=%b exp=000", busy); end
        checks++; if ({rxd0, rxd1, rxd2} !== 32'h0) begin fails++; $display("FAIL rst_rx_data got=%h exp=0", {rxd0, rxd1, rxd2}); end
        rst_n = 1'b1;
        wait_cyc(6);
    endtask

    task automatic test_mode0;
        logic [31:0] ms;
        logic v2, v3;
        txd0 = 8'h3C;
        cs_begin(0);
        checks++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL m0_busy got=%b exp=1", busy[0]); end
        xfer_word(0, 1'b0, 1'b0, 8, 1'b0, 32'hA5, ms, v2, v3);
        checks++; if (v2 !== 1'b0) begin fails++; $display("FAIL m0_latency_early got=%b exp=0", v2); end
        checks++; if (v3 !== 1'b1) begin fails++; $display("FAIL m0_latency got=%b exp=1", v3); end
        cs_end(0);
        checks++; if (rxd0 !== 8'hA5) begin fails++; $display("FAIL m0_rx_data got=%h exp=a5", rxd0); end
        checks++; if (rx_valid[0] !== 1'b1) begin fails++; $display("FAIL m0_rx_valid got=%b exp=1", rx_valid[0]); end
        checks++; if (ms[7:0] !== 8'h3C) begin fails++; $display("FAIL m0_miso_seq got=%h exp=3c", ms[7:0]); end
        checks++; if (miso[0] !== 1'b0) begin fails++; $display("FAIL m0_idle_miso got=%b exp=0", miso[0]); end
        checks++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL m0_idle_busy got=%b exp=0", busy[0]); end
        ack(0);
        checks++; if (rx_valid[0] !== 1'b0) begin fails++; $display("FAIL m0_ack got=%b exp=0", rx_valid[0]); end
    endtask

    task automatic test_cpol1_cpha1;
        logic [31:0] ms;
        logic v2, v3;
        txd1 = 8'hC3;
        cs_begin(1);
        xfer_word(1, 1'b1, 1'b1, 8, 1'b0, 32'h5A, ms, v2, v3);
        cs_end(1);
        checks++; if (rxd1 !== 8'h5A) begin fails++; $display("FAIL m3_rx_data got=%h exp=5a", rxd1); end
        checks++; if (rx_valid[1] !== 1'b1) begin fails++; $display("FAIL m3_rx_valid got=%b exp=1", rx_valid[1]); end
        checks++; if (ms[7:0] !== 8'hC3) begin fails++; $display("FAIL m3_miso_seq got=%h exp=c3", ms[7:0]); end
        checks++; if (v3 !== 1'b1) begin fails++; $display("FAIL m3_latency got=%b exp=1", v3); end
        ack(1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] ms1, ms2;
        logic v2, v3;
        int ld0;
        txd0 = 8'h96;
        ld0 = ld_cnt[0];
        cs_begin(0);
        xfer_word(0, 1'b0, 1'b0, 8, 1'b0, 32'h11, ms1, v2, v3);
        xfer_word(0, 1'b0, 1'b0, 8, 1'b0, 32'h22, ms2, v2, v3);
        cs_end(0);
        // entry load plus one reload after each completed word
        checks++; if (ld_cnt[0] - ld0 !== 3) begin fails++; $display("FAIL b2b_tx_load got=%0d exp=3", ld_cnt[0] - ld0); end
        checks++; if (rxd0 !== 8'h22) begin fails++; $display("FAIL b2b_rx_data got=%h exp=22", rxd0); end
        checks++; if (rx_overrun[0] !== 1'b1) begin fails++; $display("FAIL b2b_overrun got=%b exp=1", rx_overrun[0]); end
        checks++; if (ms2[7:0] !== 8'h96) begin fails++; $display("FAIL b2b_reload_miso got=%h exp=96", ms2[7:0]); end
        ovr_clr[0] = 1'b1;
        wait_cyc(1);
        ovr_clr[0] = 1'b0;
        wait_cyc(1);
        checks++; if (rx_overrun[0] !== 1'b0) begin fails++; $display("FAIL b2b_ovr_clr got=%b exp=0", rx_overrun[0]); end
        ack(0);
    endtask

    task automatic test_abort;
        logic [31:0] ms;
        logic v2, v3;
        cs_begin(0);
        xfer_word(0, 1'b0, 1'b0, 5, 1'b0, 32'h1F, ms, v2, v3);
        cs_end(0);
        checks++; if (rx_valid[0] !== 1'b0) begin fails++; $display("FAIL abort_rx_valid got=%b exp=0", rx_valid[0]); end
        cs_begin(0);
        xfer_word(0, 1'b0, 1'b0, 8, 1'b0, 32'h81, ms, v2, v3);
        cs_end(0);
        checks++; if (rxd0 !== 8'h81) begin fails++; $display("FAIL abort_next_word got=%h exp=81", rxd0); end
        checks++; if (rx_valid[0] !== 1'b1) begin fails++; $display("FAIL abort_next_valid got=%b exp=1", rx_valid[0]); end
        ack(0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] ms;
        logic v2, v3;
        cs_begin(0);
        xfer_word(0, 1'b0, 1'b0, 4, 1'b0, 32'h0F, ms, v2, v3);
        rst_n = 1'b0;
        wait_cyc(3);
        checks++; if ({miso[0], tx_load[0], rx_valid[0], rx_overrun[0], busy[0]} !== 5'b0)
            begin fails++; $display("FAIL rmid_flags got=%b exp=00000", {miso[0], tx_load[0], rx_valid[0], rx_overrun[0], busy[0]}); end
        checks++; if (rxd0 !== 8'h00) begin fails++; $display("FAIL rmid_rx_data got=%h exp=00", rxd0); end
        rst_n = 1'b1;
        wait_cyc(6);
        xfer_word(0, 1'b0, 1'b0, 4, 1'b0, 32'h0A, ms, v2, v3);
        checks++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL rmid_stay_idle got=%b exp=0", busy[0]); end
        checks++; if (rx_valid[0] !== 1'b0) begin fails++; $display("FAIL rmid_no_word got=%b exp=0", rx_valid[0]); end
        cs_end(0);
        cs_begin(0);
        xfer_word(0, 1'b0, 1'b0, 8, 1'b0, 32'h6D, ms, v2, v3);
        cs_end(0);
        checks++; if (rxd0 !== 8'h6D) begin fails++; $display("FAIL rmid_next_word got=%h exp=6d", rxd0); end
        ack(0);
    endtask

    task automatic test_lsb16;
        logic [31:0] ms;
        logic v2, v3;
        txd2 = 16'h1234;
        cs_begin(2);
        xfer_word(2, 1'b0, 1'b0, 16, 1'b1, 32'hBEEF, ms, v2, v3);
        cs_end(2);
        checks++; if (rxd2 !== 16'hBEEF) begin fails++; $display("FAIL lsb16_rx_data got=%h exp=beef", rxd2); end
        checks++; if (rx_valid[2] !== 1'b1) begin fails++; $display("FAIL lsb16_rx_valid got=%b exp=1", rx_valid[2]); end
        checks++; if (ms[15:0] !== 16'h1234) begin fails++; $display("FAIL lsb16_miso_seq got=%h exp=1234", ms[15:0]); end
        ack(2);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_cpol1_cpha1();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_lsb16();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, fails);
        $fatal(1);
    end

endmodule

// File: doc/spi_slave_nbit.md
SPI_SLAVE_NBIT -- requirements
Module: spi_slave_nbit

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits (2..32).
REQ-002 Parameter CPOL, default 0, SCK idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-005 Parameter SYNC_STAGES, default 2, synchroniser depth for CS_N/SCK/MOSI (min 2).
REQ-006 sys_clk  input  1  single system clock, rising edge; the only clock in the block.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 CS_N  input  1  SPI chip select, active low, asynchronous to sys_clk.
REQ-009 SCK  input  1  SPI serial clock, asynchronous; sampled as data, never used as a clock.
REQ-010 MOSI  input  1  serial data in, asynchronous.
REQ-011 MISO  output  1  serial data out, registered in sys_clk.
REQ-012 tx_data  input  DATA_W  next word to transmit.
REQ-013 tx_load  output  1  one-cycle pulse: tx_data captured into the shifter this cycle.
REQ-014 rx_data  output  DATA_W  last completed received word.
REQ-015 rx_valid  output  1  high from word completion until rx_ack.
REQ-016 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-017 rx_overrun  output  1  sticky: word completed while rx_valid was high.
REQ-018 ovr_clr  input  1  clears rx_overrun.
REQ-019 busy  output  1  high while synchronised CS_N is low.

Function
REQ-020 CS_N, SCK, MOSI SHALL each pass through SYNC_STAGES flops; edges SHALL be detected by comparing the last stage with one further registered copy.
REQ-021 Leading edge = SCK leaving CPOL; trailing edge = SCK returning to CPOL; sample edge = leading if CPHA=0, trailing if CPHA=1; the other edge is the shift edge.
REQ-022 Supported SCK: each high and low phase at least SYNC_STAGES+2 sys_clk periods; faster SCK is out of contract.
REQ-023 States: IDLE (CS_N high), ACTIVE (CS_N low); IDLE->ACTIVE on synchronised CS_N fall, ACTIVE->IDLE on synchronised CS_N rise.
REQ-024 On IDLE->ACTIVE: bit counter := 0, tx shifter := tx_data, tx_load pulses one cycle.
REQ-025 On each sample edge in ACTIVE: the MOSI synchroniser output SHALL be shifted into the rx shifter (at the LSB end if MSB_FIRST, else the MSB end); bit counter increments.
REQ-026 When the counter reaches DATA_W on a sample edge, the next cycle SHALL load rx_data with the full word, set rx_valid, and reset the counter to 0 (wrap).
REQ-027 If rx_valid is already high at word completion, rx_data SHALL still be overwritten and rx_overrun set.
REQ-028 rx_ack and completion in the same cycle: rx_valid stays 1 (new word wins).
REQ-029 ovr_clr and a new overrun in the same cycle: rx_overrun stays 1.
REQ-030 MISO SHALL present the shifter's first-out bit (MSB if MSB_FIRST, else LSB); on each shift edge the shifter advances one bit.
REQ-031 CPHA=0: the first bit is on MISO from entry to ACTIVE. CPHA=1: the shifter advances only from the second shift edge of each word onward, so the first bit is valid before the first sample edge.
REQ-032 Multi-word transfers: at the shift edge following word completion, the shifter SHALL reload from tx_data (tx_load pulse) instead of shifting.
REQ-033 On CS_N rise mid-word: partial bits SHALL be discarded and rx_valid not asserted; the counter clears.
REQ-034 MISO SHALL be 0 in IDLE.
REQ-035 Latency: rx_valid rises exactly one sys_clk cycle after the detected sample edge of the final bit.

Reset
REQ-036 While rst_n low: MISO=0, rx_data=0, rx_valid=0, rx_overrun=0, tx_load=0, busy=0, shifters/counter=0, state IDLE, synchroniser CS_N stages=1, SCK stages=CPOL.
REQ-037 Reset release during an active transfer: the block SHALL stay IDLE until a fresh synchronised CS_N fall.

Verification
REQ-038 Mode 0, DATA_W=8: tx_data=0x3C, MOSI 0xA5 -> rx_data=0xA5, rx_valid=1, MISO bits 0,0,1,1,1,1,0,0.
REQ-039 CPOL=1, CPHA=1: MOSI 0x5A, tx_data=0xC3 -> rx_data=0x5A, MISO sequence 1,1,0,0,0,0,1,1 valid at each sample edge.
REQ-040 Two back-to-back words 0x11, 0x22 in one CS_N low, no rx_ack -> rx_data=0x22, rx_overrun=1, two tx_load pulses after entry.
REQ-041 CS_N raised after 5 bits -> rx_valid stays 0; a following full word 0x81 -> rx_data=0x81.
REQ-042 rst_n low for 3 cycles mid-word (bit 4) -> all outputs 0; the next full word is received correctly only after a new CS_N fall.
REQ-043 DATA_W=16, MSB_FIRST=0: MOSI LSB-first 0xBEEF -> rx_data=0xBEEF; tx_data=0x1234 -> MISO LSB first.
